// File: rtl/ppu_issue_ctrl.sv
// ppu_issue_ctrl: round-robin, credit-based issue of NREQ requesters into one fixed-latency ppu core.
// Optional PPU_ISSUE_PERF_CNT_EN adds saturating issued/blocked performance counters.
module ppu_issue_ctrl #(
    parameter int N        = 16,
    parameter int NREQ     = 2,
    parameter int TAG_W    = 4,
    parameter int CORE_LAT = 2,
    parameter int DEPTH    = 4,
    parameter int OP_SIZE  = 4,
    localparam int ID_W    = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         i_req_valid,
    output logic [NREQ-1:0]         o_req_ready,
    input  logic [NREQ*N-1:0]       i_req_p1,
    input  logic [NREQ*N-1:0]       i_req_p2,
    input  logic [NREQ*OP_SIZE-1:0] i_req_op,
    input  logic [NREQ*TAG_W-1:0]   i_req_tag,
    output logic [N-1:0]            o_core_p1,
    output logic [N-1:0]            o_core_p2,
    output logic [OP_SIZE-1:0]      o_core_op,
    output logic                    o_core_stall,
    input  logic [N-1:0]            i_core_pout,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [N-1:0]            o_rsp_pout,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic [TAG_W-1:0]        o_rsp_tag
`ifdef PPU_ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]             o_perf_issued,
    output logic [31:0]             o_perf_blocked
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ID_W-1:0]  r_rr, w_gnt;
    logic             w_any, w_can, w_issue, w_push, w_pop;
    logic [CNT_W-1:0] r_count, w_infl;
    logic [PTR_W-1:0] r_wr, r_rd;
    logic             r_pv   [CORE_LAT];
    logic [ID_W-1:0]  r_pid  [CORE_LAT];
    logic [TAG_W-1:0] r_ptag [CORE_LAT];
    logic [N-1:0]     r_mpout[DEPTH];
    logic [ID_W-1:0]  r_mid  [DEPTH];
    logic [TAG_W-1:0] r_mtag [DEPTH];

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        for (int k = 0; k < NREQ; k++)
            if (!w_any && i_req_valid[(int'(r_rr) + k) % NREQ]) begin
                w_any = 1'b1;
                w_gnt = ID_W'((int'(r_rr) + k) % NREQ);
            end
    end

    always_comb begin
        w_infl = '0;
        for (int k = 0; k < CORE_LAT; k++)
            w_infl = w_infl + CNT_W'(r_pv[k]);
    end

    // every op reserves a FIFO slot from issue until it is popped, so pushes never overflow
    assign w_can   = !rst && ((int'(r_count) + int'(w_infl)) < DEPTH);
    assign w_issue = w_any && w_can;

    always_comb begin
        o_req_ready = '0;
        if (w_issue)
            o_req_ready[w_gnt] = 1'b1;
    end

    assign o_core_p1    = w_issue ? i_req_p1[w_gnt*N +: N] : '0;
    assign o_core_p2    = w_issue ? i_req_p2[w_gnt*N +: N] : '0;
    assign o_core_op    = w_issue ? i_req_op[w_gnt*OP_SIZE +: OP_SIZE] : '0;
    assign o_core_stall = 1'b0;

    assign w_push      = r_pv[CORE_LAT-1];
    assign o_rsp_valid = (r_count != '0);
    assign w_pop       = o_rsp_valid && i_rsp_ready;
    assign o_rsp_pout  = r_mpout[r_rd];
    assign o_rsp_id    = r_mid[r_rd];
    assign o_rsp_tag   = r_mtag[r_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr    <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int k = 0; k < CORE_LAT; k++)
                r_pv[k] <= 1'b0;
        end else begin
            if (w_issue)
                r_rr <= (w_gnt == ID_W'(NREQ - 1)) ? '0 : w_gnt + ID_W'(1);
            r_pv[0] <= w_issue;
            for (int k = 1; k < CORE_LAT; k++)
                r_pv[k] <= r_pv[k-1];
            if (w_push)
                r_wr <= f_inc(r_wr);
            if (w_pop)
                r_rd <= f_inc(r_rd);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        r_pid[0]  <= w_gnt;
        r_ptag[0] <= i_req_tag[w_gnt*TAG_W +: TAG_W];
        for (int k = 1; k < CORE_LAT; k++) begin
            r_pid[k]  <= r_pid[k-1];
            r_ptag[k] <= r_ptag[k-1];
        end
        if (w_push) begin
            r_mpout[r_wr] <= i_core_pout;
            r_mid[r_wr]   <= r_pid[CORE_LAT-1];
            r_mtag[r_wr]  <= r_ptag[CORE_LAT-1];
        end
    end

    always_ff @(posedge clk)
        if (!rst)
            assert (!(w_push && !w_pop && r_count == CNT_W'(DEPTH)));

`ifdef PPU_ISSUE_PERF_CNT_EN
    logic [31:0] r_pi, r_pb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pi <= '0;
            r_pb <= '0;
        end else begin
            if (w_issue && !(&r_pi))
                r_pi <= r_pi + 32'd1;
            if ((|i_req_valid) && !w_can && !(&r_pb))
                r_pb <= r_pb + 32'd1;
        end
    end

    assign o_perf_issued  = r_pi;
    assign o_perf_blocked = r_pb;
`endif
endmodule

// File: tb/tb_ppu_issue_ctrl.sv
// tb_ppu_issue_ctrl: directed self-checking bench for ppu_issue_ctrl with a behavioural 2-cycle core.
// Perf counter checks are compiled in when PPU_ISSUE_PERF_CNT_EN is defined.
module tb_ppu_issue_ctrl;
    localparam int N = 16, NREQ = 2, TAG_W = 4, CORE_LAT = 2, DEPTH = 4, OP_SIZE = 4;
    localparam logic [OP_SIZE-1:0] ADD = 4'd0;

    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  req_valid = '0, req_ready;
    logic [31:0] req_p1 = '0, req_p2 = '0;
    logic [7:0]  req_op = '0, req_tag = '0;
    logic [15:0] core_p1, core_p2, core_pout, rsp_pout;
    logic [3:0]  core_op, rsp_tag;
    logic        core_stall, rsp_valid, rsp_ready = 1'b0;
    logic [0:0]  rsp_id;
`ifdef PPU_ISSUE_PERF_CNT_EN
    logic [31:0] perf_issued, perf_blocked;
`endif
    int n_chk = 0, n_fail = 0;

    ppu_issue_ctrl #(.N(N), .NREQ(NREQ), .TAG_W(TAG_W), .CORE_LAT(CORE_LAT), .DEPTH(DEPTH), .OP_SIZE(OP_SIZE)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_p1(req_p1), .i_req_p2(req_p2), .i_req_op(req_op), .i_req_tag(req_tag),
        .o_core_p1(core_p1), .o_core_p2(core_p2), .o_core_op(core_op), .o_core_stall(core_stall),
        .i_core_pout(core_pout),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_pout(rsp_pout), .o_rsp_id(rsp_id), .o_rsp_tag(rsp_tag)
`ifdef PPU_ISSUE_PERF_CNT_EN
        , .o_perf_issued(perf_issued), .o_perf_blocked(perf_blocked)
`endif
    );

    always #5 clk = ~clk;

    // behavioural core: 1+1=2 for the posit ADD case, otherwise a simple xor mix
    function automatic logic [15:0] core_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        return (a == 16'h4000 && b == 16'h4000 && op == ADD) ? 16'h5000 : a ^ b ^ {12'h000, op};
    endfunction

    logic [15:0] c0 = '0, c1 = '0;
    always @(posedge clk) begin
        c0 <= core_f(core_p1, core_p2, core_op);
        c1 <= c0;
    end
    assign core_pout = c1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] p1, input logic [15:0] p2, input logic [3:0] op, input logic [3:0] tg);
        req_p1[i*16 +: 16] = p1;
        req_p2[i*16 +: 16] = p2;
        req_op[i*4 +: 4]   = op;
        req_tag[i*4 +: 4]  = tg;
    endtask

    initial begin
        int id, tg;
        set_req(0, 16'h1111, 16'h0101, 4'd1, 4'hA);
        set_req(1, 16'h2222, 16'h0202, 4'd2, 4'hB);
        repeat (3) tick;
        req_valid = 2'b01;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_core_p1", 32'(core_p1), 32'd0);
        chk("core_stall", 32'(core_stall), 32'd0);
        tick;
        rst = 1'b0;
        rsp_ready = 1'b1;
        // req1 alone from rr_ptr=0, then both held: grants 1 | 0,1,0,1
        for (int k = 1; k <= 9; k++) begin
            req_valid = (k == 1) ? 2'b10 : (k <= 5) ? 2'b11 : 2'b00;
            #1;
            chk("rr_req_ready", 32'(req_ready), (k > 5) ? 32'd0 : (k % 2 == 1) ? 32'd2 : 32'd1);
            if (k == 1)
                chk("req1_core_p1", 32'(core_p1), 32'h2222);
            chk("rr_rsp_valid", 32'(rsp_valid), 32'(k >= 4 && k <= 8));
            if (k >= 4 && k <= 8) begin
                id = ((k - 3) % 2 == 1) ? 1 : 0;
                chk("rr_rsp_id", 32'(rsp_id), 32'(id));
                chk("rr_rsp_pout", 32'(rsp_pout), (id == 1) ? 32'h2022 : 32'h1011);
                chk("rr_rsp_tag", 32'(rsp_tag), (id == 1) ? 32'hB : 32'hA);
            end
            tick;
        end
        // single ADD, latency 3
        set_req(0, 16'h4000, 16'h4000, ADD, 4'd3);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1;
        chk("t1_req_ready", 32'(req_ready), 32'd1);
        chk("t1_core_p1", 32'(core_p1), 32'h4000);
        chk("t1_core_p2", 32'(core_p2), 32'h4000);
        tick;
        req_valid = 2'b00;
        #1;
        chk("t1_idle_core_p1", 32'(core_p1), 32'd0);
        chk("t1_rsp_valid_t1", 32'(rsp_valid), 32'd0);
        tick;
        #1;
        chk("t1_rsp_valid_t2", 32'(rsp_valid), 32'd0);
        tick;
        #1;
        chk("t1_rsp_valid_t3", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_pout", 32'(rsp_pout), 32'h5000);
        chk("t1_rsp_id", 32'(rsp_id), 32'd0);
        chk("t1_rsp_tag", 32'(rsp_tag), 32'd3);
        rsp_ready = 1'b1;
        tick;
        #1;
        chk("t1_drained", 32'(rsp_valid), 32'd0);
        tick;
        // consumer stalled: exactly DEPTH accepts
        rsp_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            req_valid = 2'b01;
            set_req(0, 16'(32'h100 * k), 16'h0000, ADD, 4'(k));
            #1;
            chk("fill_req_ready", 32'(req_ready), (k <= 4) ? 32'd1 : 32'd0);
            tick;
        end
        #1;
        chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("full_rsp_tag", 32'(rsp_tag), 32'd1);
`ifdef PPU_ISSUE_PERF_CNT_EN
        chk("perf_blocked_fill", perf_blocked, 32'd4);
        chk("perf_issued_fill", perf_issued, 32'd10);
`endif
        // release while still streaming: in-order drain with refills
        for (int k = 1; k <= 7; k++) begin
            rsp_ready = 1'b1;
            req_valid = (k <= 3) ? 2'b01 : 2'b00;
            tg = (k < 2) ? 5 : k + 3;
            set_req(0, 16'(32'h100 * tg), 16'h0000, ADD, 4'(tg));
            #1;
            if (k <= 3)
                chk("drain_req_ready", 32'(req_ready), (k == 1) ? 32'd0 : 32'd1);
            chk("drain_rsp_valid", 32'(rsp_valid), 32'(k <= 6));
            if (k <= 6) begin
                chk("drain_rsp_tag", 32'(rsp_tag), 32'(k));
                chk("drain_rsp_pout", 32'(rsp_pout), 32'h100 * k);
                chk("drain_rsp_id", 32'(rsp_id), 32'd0);
            end
            tick;
        end
`ifdef PPU_ISSUE_PERF_CNT_EN
        #1;
        chk("perf_blocked_drain", perf_blocked, 32'd5);
        chk("perf_issued_drain", perf_issued, 32'd12);
`endif
        // reset with two ops in flight
        set_req(0, 16'h1111, 16'h0101, 4'd1, 4'hA);
        set_req(1, 16'h2222, 16'h0202, 4'd2, 4'hB);
        req_valid = 2'b11;
        #1;
        chk("r_grant1", 32'(req_ready), 32'd2);
        tick;
        #1;
        chk("r_grant0", 32'(req_ready), 32'd1);
        tick;
        rst = 1'b1;
        #1;
        chk("r_rst_ready", 32'(req_ready), 32'd0);
        tick;
        rst = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("r_rsp_valid_a", 32'(rsp_valid), 32'd0);
        tick;
        req_valid = 2'b11;
        #1;
        chk("r_rsp_valid_b", 32'(rsp_valid), 32'd0);
        chk("r_rr_reset", 32'(req_ready), 32'd1);
        tick;
        req_valid = 2'b00;
        #1;
        chk("r_rsp_valid_c", 32'(rsp_valid), 32'd0);
        tick;
        #1;
        chk("r_rsp_valid_d", 32'(rsp_valid), 32'd0);
        tick;
        #1;
        chk("r_rsp_valid_e", 32'(rsp_valid), 32'd1);
        chk("r_rsp_id", 32'(rsp_id), 32'd0);
        chk("r_rsp_tag", 32'(rsp_tag), 32'hA);
        chk("r_rsp_pout", 32'(rsp_pout), 32'h1011);
`ifdef PPU_ISSUE_PERF_CNT_EN
        chk("perf_issued_rst", perf_issued, 32'd1);
        chk("perf_blocked_rst", perf_blocked, 32'd0);
`endif
        tick;
        #1;
        chk("r_rsp_drained", 32'(rsp_valid), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
